// File: rtl/hdmi_period_sched.sv
// Raster timing and TMDS period sequencer for one DVI/HDMI output.
// Stage 0 runs the raster counters and drives the pixel source.
// Stage 1 registers the period and override symbols. This keeps them aligned
// with the one-cycle registered output of the TMDS encoders.
module hdmi_period_sched #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        de,
    output logic        frame_start,
    output logic        use_enc,
    output logic [9:0]  sym0,
    output logic [9:0]  sym1,
    output logic [9:0]  sym2,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic [1:0]  period_o
);

    // Raster constants, all 12-bit so every compare stays at counter width.
    localparam logic [11:0] H_ACT_C   = 12'(H_ACTIVE);
    localparam logic [11:0] HT_M1     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] HS_START  = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] PRE_START = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 10);
    localparam logic [11:0] PRE_END   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 3);
    localparam logic [11:0] GB_START  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 2);
    localparam logic [11:0] V_ACT_C   = 12'(V_ACTIVE);
    localparam logic [11:0] V_ACT_M1  = 12'(V_ACTIVE - 1);
    localparam logic [11:0] VT_M1     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] VS_START  = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Period states.
    localparam logic [1:0] P_CTRL  = 2'd0;
    localparam logic [1:0] P_PRE   = 2'd1;
    localparam logic [1:0] P_GUARD = 2'd2;
    localparam logic [1:0] P_VIDEO = 2'd3;

    // TMDS control and video guard-band symbols.
    localparam logic [9:0] CTL_00 = 10'b1101010100;
    localparam logic [9:0] CTL_01 = 10'b0010101011;
    localparam logic [9:0] CTL_10 = 10'b0101010100;
    localparam logic [9:0] CTL_11 = 10'b1010101011;
    localparam logic [9:0] GB_02  = 10'b1011001100;
    localparam logic [9:0] GB_1   = 10'b0100110011;

    function automatic logic [9:0] ctl_sym(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = CTL_00;
            2'b01:   s = CTL_01;
            2'b10:   s = CTL_10;
            default: s = CTL_11;
        endcase
        return s;
    endfunction

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;
    logic [1:0]  period_q, period_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [9:0]  sym0_q, sym0_d;
    logic [9:0]  sym1_q, sym1_d;
    logic [9:0]  sym2_q, sym2_d;

    logic de_s0;
    logic hs_act;
    logic vs_act;
    logic next_active_line;
    logic pre_win;
    logic gb_win;

    // Raster counter next state. en low parks the counters in blanking.
    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!en) begin
            h_d = H_ACT_C;
            v_d = V_ACT_C;
        end else if (h_q == HT_M1) begin
            h_d = 12'd0;
            v_d = (v_q == VT_M1) ? 12'd0 : v_q + 12'd1;
        end else begin
            h_d = h_q + 12'd1;
        end
    end

    // Stage-0 decode. vs_act follows v, which only moves at h wrap.
    always_comb begin
        de_s0            = (h_q < H_ACT_C) && (v_q < V_ACT_C);
        hs_act           = (h_q >= HS_START) && (h_q <= HS_END);
        vs_act           = (v_q >= VS_START) && (v_q <= VS_END);
        next_active_line = (v_q == VT_M1) || (v_q < V_ACT_M1);
        pre_win          = (h_q >= PRE_START) && (h_q <= PRE_END);
        gb_win           = (h_q >= GB_START);
    end

    // Period, sync and override-symbol selection for the next stage-1 cycle.
    always_comb begin
        period_d = P_CTRL;
        if (!en) begin
            period_d = P_CTRL;
        end else if (de_s0) begin
            period_d = P_VIDEO;
        end else if (next_active_line && pre_win) begin
            period_d = P_PRE;
        end else if (next_active_line && gb_win) begin
            period_d = P_GUARD;
        end
        hsync_d = hs_act ? HS_POL : ~HS_POL;
        vsync_d = vs_act ? VS_POL : ~VS_POL;
        sym0_d  = ctl_sym({vsync_d, hsync_d});
        sym1_d  = CTL_00;
        sym2_d  = CTL_00;
        case (period_d)
            P_PRE: begin
                sym1_d = CTL_01;
            end
            P_GUARD: begin
                sym0_d = GB_02;
                sym1_d = GB_1;
                sym2_d = GB_02;
            end
            default: begin
            end
        endcase
    end

    // Stage-0 counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q <= H_ACT_C;
            v_q <= V_ACT_C;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // Stage-1 period and symbol registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= P_CTRL;
            hsync_q  <= ~HS_POL;
            vsync_q  <= ~VS_POL;
            sym0_q   <= CTL_00;
            sym1_q   <= CTL_00;
            sym2_q   <= CTL_00;
        end else begin
            period_q <= period_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            sym0_q   <= sym0_d;
            sym1_q   <= sym1_d;
            sym2_q   <= sym2_d;
        end
    end

    assign x           = h_q;
    assign y           = v_q;
    assign de          = de_s0;
    assign frame_start = (h_q == 12'd0) && (v_q == 12'd0);
    assign use_enc     = (period_q == P_VIDEO);
    assign sym0        = sym0_q;
    assign sym1        = sym1_q;
    assign sym2        = sym2_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign period_o    = period_q;

endmodule
